// File: rtl/ycr1_tapc_ctrl.sv
// ycr1_tapc_ctrl
// JTAG TAP controller for the debug subsystem. It runs the 16-state
// 1149.1 FSM, holds and decodes the instruction register, generates the
// data-register strobes and muxes the selected serial output onto tdo.
//
// Ports:
//   clk, rst            TCK clock, asynchronous active-high reset (TRST)
//   tms, tdi            test mode select / test data in, sampled on posedge
//   tdo, tdo_en         serial out and its enable (SHIFT_IR / SHIFT_DR only)
//   tlr_n               low while in TEST_LOGIC_RESET
//   dr_sel_*            one-hot DR select decoded from ir_value
//   dr_capture/shift/update  state decodes; the DR acts on the edge leaving
//                       the state
//   dr_*_tdo            serial outputs of the individual DRs
//   ir_value            current (updated) instruction
module ycr1_tapc_ctrl #(
    parameter int unsigned             IR_WIDTH  = 5,
    parameter logic [IR_WIDTH-1:0]     IR_IDCODE = 5'h01,
    parameter logic [IR_WIDTH-1:0]     IR_DTMCS  = 5'h10,
    parameter logic [IR_WIDTH-1:0]     IR_DMI    = 5'h11,
    parameter logic [IR_WIDTH-1:0]     IR_BYPASS = 5'h1F
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                tlr_n,
    output logic                dr_sel_idcode,
    output logic                dr_sel_dtmcs,
    output logic                dr_sel_dmi,
    output logic                dr_sel_bypass,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    input  logic                dr_idcode_tdo,
    input  logic                dr_dtmcs_tdo,
    input  logic                dr_dmi_tdo,
    input  logic                dr_bypass_tdo,
    output logic [IR_WIDTH-1:0] ir_value
);

    typedef enum logic [3:0] {
        ST_TLR,
        ST_RTI,
        ST_SEL_DR,
        ST_CAP_DR,
        ST_SHIFT_DR,
        ST_EXIT1_DR,
        ST_PAUSE_DR,
        ST_EXIT2_DR,
        ST_UPDATE_DR,
        ST_SEL_IR,
        ST_CAP_IR,
        ST_SHIFT_IR,
        ST_EXIT1_IR,
        ST_PAUSE_IR,
        ST_EXIT2_IR,
        ST_UPDATE_IR
    } tap_state_e;

    // Fixed 1149.1 capture pattern: LSBs 2'b01, rest zero.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    tap_state_e          state;
    tap_state_e          next_state;
    logic [IR_WIDTH-1:0] ir_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_TLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tlr_n      = 1'b1;
        dr_capture = 1'b0;
        dr_shift   = 1'b0;
        dr_update  = 1'b0;
        tdo_en     = 1'b0;
        unique case (state)
            ST_TLR: begin
                tlr_n      = 1'b0;
                next_state = tms ? ST_TLR : ST_RTI;
            end
            ST_RTI:       next_state = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:    next_state = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_SEL_IR:    next_state = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_DR: begin
                dr_capture = 1'b1;
                next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            end
            ST_SHIFT_DR: begin
                dr_shift   = 1'b1;
                tdo_en     = 1'b1;
                next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            end
            ST_EXIT1_DR:  next_state = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:  next_state = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:  next_state = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR: begin
                dr_update  = 1'b1;
                next_state = tms ? ST_SEL_DR : ST_RTI;
            end
            ST_CAP_IR:    next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: begin
                tdo_en     = 1'b1;
                next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            end
            ST_EXIT1_IR:  next_state = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:  next_state = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:  next_state = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR: next_state = tms ? ST_SEL_DR    : ST_RTI;
            default:      next_state = ST_TLR;
        endcase
    end

    // IR acts on the edge leaving each state, like the DRs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_value <= IR_IDCODE;
            ir_shift <= '0;
        end else begin
            case (state)
                ST_TLR: begin
                    ir_value <= IR_IDCODE;
                    ir_shift <= '0;
                end
                ST_CAP_IR:    ir_shift <= IR_CAPTURE;
                ST_SHIFT_IR:  ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                ST_UPDATE_IR: ir_value <= ir_shift;
                default: ;
            endcase
        end
    end

    // Unknown codes fall through to BYPASS, so exactly one select is high.
    always_comb begin
        dr_sel_idcode = (ir_value == IR_IDCODE);
        dr_sel_dtmcs  = !dr_sel_idcode && (ir_value == IR_DTMCS);
        dr_sel_dmi    = !dr_sel_idcode && !dr_sel_dtmcs && (ir_value == IR_DMI);
        dr_sel_bypass = (ir_value == IR_BYPASS)
                      || !(dr_sel_idcode || dr_sel_dtmcs || dr_sel_dmi);
    end

    always_comb begin
        tdo = 1'b0;
        if (state == ST_SHIFT_IR) begin
            tdo = ir_shift[0];
        end else if (state == ST_SHIFT_DR) begin
            tdo = (dr_sel_idcode & dr_idcode_tdo)
                | (dr_sel_dtmcs  & dr_dtmcs_tdo)
                | (dr_sel_dmi    & dr_dmi_tdo)
                | (dr_sel_bypass & dr_bypass_tdo);
        end
    end

endmodule

// File: tb/tb_ycr1_tapc_ctrl.sv
module tb_ycr1_tapc_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst, tms, tdi;
    logic         tdo, tdo_en, tlr_n;
    logic         sel_id, sel_dtm, sel_dmi, sel_byp;
    logic         cap, shf, upd;
    logic         id_tdo, dtm_tdo, dmi_tdo, byp_tdo;
    logic [W-1:0] ir_value;

    always #5 clk = ~clk;

    ycr1_tapc_ctrl #(
        .IR_WIDTH (W),
        .IR_IDCODE(5'h01),
        .IR_DTMCS (5'h10),
        .IR_DMI   (5'h11),
        .IR_BYPASS(5'h1F)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .tlr_n        (tlr_n),
        .dr_sel_idcode(sel_id),
        .dr_sel_dtmcs (sel_dtm),
        .dr_sel_dmi   (sel_dmi),
        .dr_sel_bypass(sel_byp),
        .dr_capture   (cap),
        .dr_shift     (shf),
        .dr_update    (upd),
        .dr_idcode_tdo(id_tdo),
        .dr_dtmcs_tdo (dtm_tdo),
        .dr_dmi_tdo   (dmi_tdo),
        .dr_bypass_tdo(byp_tdo),
        .ir_value     (ir_value)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase within the TAP graph plus which column (DR/IR).
    // 0 TLR, 1 RTI, 2 SEL_DR, 3 SEL_IR, 4 CAPTURE, 5 SHIFT, 6 EXIT1,
    // 7 PAUSE, 8 EXIT2, 9 UPDATE
    int           m_ph;
    bit           m_col_ir;
    logic [W-1:0] m_ir_val;
    logic [W-1:0] m_ir_sh;

    typedef struct {
        logic [9:0]   o;    // {tdo,tdo_en,tlr_n,cap,shf,upd,id,dtm,dmi,byp}
        logic [W-1:0] ir;
        int           tag;
    } exp_t;

    exp_t q[$];
    int   tag_cnt = 0;

    function automatic void model_reset();
        m_ph     = 0;
        m_col_ir = 1'b0;
        m_ir_val = 5'h01;
        m_ir_sh  = 5'h00;
    endfunction

    function automatic void model_edge(input bit t, input bit d);
        if (m_ph == 0) begin
            m_ir_val = 5'h01;
            m_ir_sh  = 5'h00;
        end else if (m_col_ir && m_ph == 4) begin
            m_ir_sh = 5'h01;
        end else if (m_col_ir && m_ph == 5) begin
            m_ir_sh = (m_ir_sh >> 1) | (5'(d) << (W - 1));
        end else if (m_col_ir && m_ph == 9) begin
            m_ir_val = m_ir_sh;
        end
        case (m_ph)
            0: m_ph = t ? 0 : 1;
            1: m_ph = t ? 2 : 1;
            2: begin
                if (t) m_ph = 3;
                else begin m_ph = 4; m_col_ir = 1'b0; end
            end
            3: begin
                if (t) m_ph = 0;
                else begin m_ph = 4; m_col_ir = 1'b1; end
            end
            4: m_ph = t ? 6 : 5;
            5: m_ph = t ? 6 : 5;
            6: m_ph = t ? 9 : 7;
            7: m_ph = t ? 8 : 7;
            8: m_ph = t ? 9 : 5;
            default: m_ph = t ? 2 : 1;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t       e;
        logic [3:0] sel;
        logic       dr_bit;
        logic       o_tdo;
        case (m_ir_val)
            5'h01:   sel = 4'b1000;
            5'h10:   sel = 4'b0100;
            5'h11:   sel = 4'b0010;
            default: sel = 4'b0001;
        endcase
        dr_bit = sel[3] ? id_tdo : sel[2] ? dtm_tdo : sel[1] ? dmi_tdo : byp_tdo;
        o_tdo  = 1'b0;
        if (m_ph == 5) o_tdo = m_col_ir ? m_ir_sh[0] : dr_bit;
        e.o   = {o_tdo, (m_ph == 5), (m_ph != 0),
                 (m_ph == 4 && !m_col_ir), (m_ph == 5 && !m_col_ir),
                 (m_ph == 9 && !m_col_ir), sel};
        e.ir  = m_ir_val;
        e.tag = tag_cnt;
        return e;
    endfunction

    // One TCK cycle: drive inputs after the falling edge, advance the model
    // through the coming rising edge and queue the outputs expected after it.
    task automatic step(input bit t, input bit d, input bit r);
        exp_t e;
        @(negedge clk);
        #1;
        tms     = t;
        tdi     = d;
        rst     = r;
        id_tdo  = 1'($urandom_range(1));
        dtm_tdo = 1'($urandom_range(1));
        dmi_tdo = 1'($urandom_range(1));
        byp_tdo = 1'($urandom_range(1));
        if (r) model_reset();
        else   model_edge(t, d);
        tag_cnt++;
        e = model_out();
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Observe the DUT just after the edge belonging to the last step.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs of each step are presented before the next fall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({tdo, tdo_en, tlr_n, cap, shf, upd, sel_id, sel_dtm, sel_dmi, sel_byp} !== e.o) begin
                    bad++;
                    $display("FAIL outputs step=%0d got %b want %b", e.tag,
                             {tdo, tdo_en, tlr_n, cap, shf, upd, sel_id, sel_dtm, sel_dmi, sel_byp}, e.o);
                end
                total++;
                if (ir_value !== e.ir) begin
                    bad++;
                    $display("FAIL ir_value step=%0d got %h want %h", e.tag, ir_value, e.ir);
                end
            end
        end
    end

    int  n_cap = 0, n_shf = 0, n_upd = 0;
    bit  cnt_on = 1'b0;
    always @(negedge clk) begin
        if (cnt_on) begin
            if (cap) n_cap++;
            if (shf) n_shf++;
            if (upd) n_upd++;
        end
    end

    task automatic load_ir(input logic [W-1:0] v);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < W; i++) step(i == W - 1, v[i], 0);
        step(1, 0, 0); step(0, 0, 0);
    endtask

    task automatic dr_scan(input int n);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < n; i++) step(0, 1'($urandom_range(1)), 0);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    endtask

    int path_len[16]  = '{0, 1, 2, 3, 3, 4, 4, 5, 6, 5, 4, 5, 5, 6, 7, 6};
    int path_bits[16] = '{0, 0, 2, 6, 2, 2, 10, 10, 42, 26, 6, 6, 22, 22, 86, 54};

    initial begin
        logic [W-1:0] codes[5] = '{5'h01, 5'h10, 5'h11, 5'h1F, 5'h07};
        rst = 1'b1; tms = 1'b1; tdi = 1'b0;
        id_tdo = 1'b0; dtm_tdo = 1'b0; dmi_tdo = 1'b0; byp_tdo = 1'b0;
        model_reset();
        #1;
        chk("por_tlr_n", int'(tlr_n), 0);
        chk("por_ir", int'(ir_value), 5'h01);
        chk("por_tdo_en", int'(tdo_en), 0);

        step(1, 0, 1); step(1, 0, 1);
        step(0, 0, 0);
        settle();
        chk("rti_tlr_n", int'(tlr_n), 1);
        chk("rti_ir", int'(ir_value), 5'h01);
        chk("rti_sel_idcode", int'(sel_id), 1);
        chk("rti_tdo_en", int'(tdo_en), 0);

        // IR <- 0x11 (DMI); captured 00001 shifts out as 1,0,0,0,0
        load_ir(5'h11);
        settle();
        chk("ir_dmi_value", int'(ir_value), 5'h11);
        chk("ir_dmi_sel", int'(sel_dmi), 1);

        load_ir(5'h07);
        settle();
        chk("ir_07_bypass", int'(sel_byp), 1);
        dr_scan(6);

        // strobe lengths on a DR scan with 8 shift cycles
        load_ir(5'h10);
        cnt_on = 1'b1;
        dr_scan(8);
        step(0, 0, 0);
        cnt_on = 1'b0;
        chk("capture_cycles", n_cap, 1);
        chk("shift_cycles", n_shf, 9);
        chk("update_cycles", n_upd, 1);

        // five tms=1 from every state
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < path_len[s]; i++)
                step(((path_bits[s] >> i) & 1) != 0, 1'($urandom_range(1)), 0);
            for (int k = 0; k < 5; k++) step(1, 1'($urandom_range(1)), 0);
            settle();
            chk($sformatf("tlr_from_%0d", s), int'(tlr_n), 0);
            step(1, 0, 0);
            settle();
            chk($sformatf("ir_reset_from_%0d", s), int'(ir_value), 5'h01);
        end

        // asynchronous reset while in SHIFT_DR
        step(0, 0, 0);
        load_ir(5'h11);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        @(negedge clk);
        #1;
        chk("pre_rst_shift", int'(shf), 1);
        rst = 1'b1;
        #1;
        chk("rst_tdo_en", int'(tdo_en), 0);
        chk("rst_dr_shift", int'(shf), 0);
        chk("rst_tlr_n", int'(tlr_n), 0);
        chk("rst_ir", int'(ir_value), 5'h01);
        model_reset();
        step(1, 0, 1);
        step(1, 0, 0);
        settle();
        chk("post_rst_tlr", int'(tlr_n), 0);

        // random walk with occasional resets
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(99) == 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] c;
            c = codes[$urandom_range(4)];
            if (i == 9) c = W'($urandom);
            load_ir(c);
            dr_scan($urandom_range(12));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ycr1_tapc_ctrl.md
Name: ycr1_tapc_ctrl

Overview:
JTAG TAP controller that sequences the TAPC data-register shift chains in the debug subsystem (built only under YCR1_DBG_EN).
- Runs the IEEE 1149.1 16-state FSM from tms.
- Holds the instruction register and decodes it into one-hot DR selects.
- Generates the capture/shift/update strobes consumed by the DR shift registers.
- Muxes the selected serial output onto tdo.

Parameters:
IR_WIDTH, 5, instruction register width in bits (>=2)
IR_IDCODE, 5'h01, IDCODE instruction code, also the IR value after reset
IR_DTMCS, 5'h10, DTM control/status instruction code
IR_DMI, 5'h11, DMI access instruction code
IR_BYPASS, 5'h1F, BYPASS instruction code

Ports:
clk  in  1  TCK-domain clock
rst  in  1  asynchronous reset, active high (TRST equivalent)
tms  in  1  test mode select, sampled on posedge clk
tdi  in  1  test data in
tdo  out  1  serial data out
tdo_en  out  1  tdo output enable
tlr_n  out  1  low while FSM is in TEST_LOGIC_RESET; drives the DR registers' rst_n_sync
dr_sel_idcode  out  1  IDCODE DR selected
dr_sel_dtmcs  out  1  DTMCS DR selected
dr_sel_dmi  out  1  DMI DR selected
dr_sel_bypass  out  1  BYPASS DR selected
dr_capture  out  1  FSM in CAPTURE_DR
dr_shift  out  1  FSM in SHIFT_DR
dr_update  out  1  FSM in UPDATE_DR
dr_idcode_tdo  in  1  IDCODE DR serial out
dr_dtmcs_tdo  in  1  DTMCS DR serial out
dr_dmi_tdo  in  1  DMI DR serial out
dr_bypass_tdo  in  1  BYPASS DR serial out
ir_value  out  IR_WIDTH  current (updated) instruction

Behaviour:
FSM
- 4-bit state register; async reset to TEST_LOGIC_RESET (TLR).
- Transitions on posedge clk, given as tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SHIFT_x / EXIT1_x
  - SHIFT_x: SHIFT_x / EXIT1_x
  - EXIT1_x: PAUSE_x / UPDATE_x
  - PAUSE_x: PAUSE_x / EXIT2_x
  - EXIT2_x: SHIFT_x / UPDATE_x
  - UPDATE_x: RTI / SEL_DR
- Five consecutive tms=1 cycles reach TLR from any state.

Strobes
- dr_capture, dr_shift, dr_update and tlr_n are combinational decodes of the state register.
- The DR register acts on the posedge that leaves the state. Shifting therefore includes the SHIFT_DR→EXIT1_DR edge, as 1149.1 requires.

IR
- ir_shift (IR_WIDTH) loads {0..., 2'b01} in CAP_IR.
- In SHIFT_IR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
- In UPDATE_IR: ir_value <= ir_shift.
- In TLR, and on rst: ir_value <= IR_IDCODE, ir_shift <= 0.
- ir_value is stable in all other states.

Decode
- dr_sel_* is a one-hot combinational decode of ir_value.
- Any code not equal to IDCODE, DTMCS or DMI selects BYPASS; this includes IR_BYPASS itself.
- Exactly one select is high at all times.

TDO
- tdo_en = state is SHIFT_IR or SHIFT_DR.
- In SHIFT_IR: tdo = ir_shift[0].
- In SHIFT_DR: tdo = serial out of the selected DR.
- Otherwise tdo = 0.
- Output is combinational. The negedge retiming required by 1149.1 is done at the pad level.

Reset and corner cases
- rst mid-operation forces TLR, ir_value=IR_IDCODE, all strobes 0, tdo_en=0 and tlr_n=0 immediately, without waiting for a clock.
- A partial IR shift that is abandoned via PAUSE→EXIT2→UPDATE still updates with the partially shifted content (standard behaviour).

Test Plan:
- Reset, then tms=0 → state RTI; ir_value=5'h01, dr_sel_idcode=1, tlr_n=1, tdo_en=0.
- From RTI, tms sequence 1,1,0,0 (SEL_DR, SEL_IR, CAP_IR, SHIFT_IR), then shift tdi bits 1,0,0,0,1 LSB-first with tms=1 on the last bit, then tms=1,0 → ir_value=5'h11, dr_sel_dmi=1. The captured pattern shifted out on tdo is 1,0,0,0,0.
- IR loaded with 5'h07 → dr_sel_bypass=1. In SHIFT_DR, tdo follows dr_bypass_tdo.
- From RTI, tms 1,0,0 (SEL_DR, CAP_DR, SHIFT_DR) → dr_capture high for exactly 1 cycle. With 8 tms=0 shift cycles, dr_shift stays high for 9 cycles including the exit edge. dr_update pulses 1 cycle after EXIT1_DR.
- From each of the 16 states, apply 5× tms=1 → TLR reached; tlr_n=0 and ir_value=5'h01.
- Assert rst during SHIFT_DR → tdo_en=0 and dr_shift=0 in the same cycle; FSM in TLR after release.
